// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a per-entry pending scoreboard and a sequenced bulk-clear engine.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the ra/rb read ports.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic              ra_pend,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    output logic              rb_pend,
    input  logic [ADDR_W-1:0] test_addr,
    output logic [DATA_W-1:0] test_data,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              sb_set_en,
    input  logic [ADDR_W-1:0] sb_set_addr,
    input  logic              clr_req,
    output logic              clr_busy
);
    localparam int NREGS = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic              clr_last;
    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pend;
    logic              wa_ok;
    logic              wb_ok;
    logic              set_ok;

    // Entry 0 is read-only zero when ZERO_REG is set.
    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wa_ok    = wa_en && writable(wa_addr);
    assign wb_ok    = wb_en && writable(wb_addr);
    assign set_ok   = sb_set_en && writable(sb_set_addr);
    assign clr_busy = (state == CLEAR);
    assign clr_last = (cnt == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clr_req) state_next = CLEAR;
            CLEAR:   if (clr_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The counter sits at 0 while idle so a clear always starts from entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (!clr_last) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Port B is written after port A so it wins on an address collision; a scoreboard set
    // is applied last so a new producer outranks a retiring write to the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pend <= '0;
        end else if (clr_busy) begin
            regs[cnt] <= '0;
            pend[cnt] <= 1'b0;
        end else begin
            if (wa_ok) begin
                regs[wa_addr] <= wa_data;
                pend[wa_addr] <= 1'b0;
            end
            if (wb_ok) begin
                regs[wb_addr] <= wb_data;
                pend[wb_addr] <= 1'b0;
            end
            if (set_ok) begin
                pend[sb_set_addr] <= 1'b1;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_en;
    assign fwd_en = !clr_busy && !rst;
`endif

    always_comb begin
        ra_data = regs[ra_addr];
        ra_pend = pend[ra_addr];
`ifdef REGFILE_BYPASS_EN
        if (fwd_en && wb_ok && (wb_addr == ra_addr)) begin
            ra_data = wb_data;
            ra_pend = 1'b0;
        end else if (fwd_en && wa_ok && (wa_addr == ra_addr)) begin
            ra_data = wa_data;
            ra_pend = 1'b0;
        end
`endif
        if (!writable(ra_addr)) begin
            ra_data = '0;
            ra_pend = 1'b0;
        end
    end

    always_comb begin
        rb_data = regs[rb_addr];
        rb_pend = pend[rb_addr];
`ifdef REGFILE_BYPASS_EN
        if (fwd_en && wb_ok && (wb_addr == rb_addr)) begin
            rb_data = wb_data;
            rb_pend = 1'b0;
        end else if (fwd_en && wa_ok && (wa_addr == rb_addr)) begin
            rb_data = wa_data;
            rb_pend = 1'b0;
        end
`endif
        if (!writable(rb_addr)) begin
            rb_data = '0;
            rb_pend = 1'b0;
        end
    end

    assign test_data = regs[test_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp with directed literal checks and a
// randomized run compared every cycle against an array-based reference model.
module tb_regfile_mp;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] ra_addr, rb_addr, test_addr, wa_addr, wb_addr, sb_set_addr;
    logic [DATA_W-1:0] ra_data, rb_data, test_data, wa_data, wb_data;
    logic              ra_pend, rb_pend, wa_en, wb_en, sb_set_en, clr_req, clr_busy;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] m_regs [NREGS];
    logic              m_pend [NREGS];
    int                clear_left = 0;

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .ra_addr(ra_addr), .ra_data(ra_data), .ra_pend(ra_pend),
        .rb_addr(rb_addr), .rb_data(rb_data), .rb_pend(rb_pend),
        .test_addr(test_addr), .test_data(test_data),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a clear simply counts down the entries still to zero, lowest first.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] <= '0;
                m_pend[i] <= 1'b0;
            end
            clear_left <= 0;
        end else if (clear_left > 0) begin
            m_regs[NREGS - clear_left] <= '0;
            m_pend[NREGS - clear_left] <= 1'b0;
            clear_left <= clear_left - 1;
        end else begin
            if (wa_en && wa_addr != 0) begin
                m_regs[wa_addr] <= wa_data;
                m_pend[wa_addr] <= 1'b0;
            end
            if (wb_en && wb_addr != 0) begin
                m_regs[wb_addr] <= wb_data;
                m_pend[wb_addr] <= 1'b0;
            end
            if (sb_set_en && sb_set_addr != 0) m_pend[sb_set_addr] <= 1'b1;
            if (clr_req) clear_left <= NREGS;
        end
    end

    function automatic void expRead(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic p);
        d = m_regs[a];
        p = m_pend[a];
`ifdef REGFILE_BYPASS_EN
        if (clear_left == 0) begin
            if (wb_en && wb_addr == a) begin
                d = wb_data;
                p = 1'b0;
            end else if (wa_en && wa_addr == a) begin
                d = wa_data;
                p = 1'b0;
            end
        end
`endif
        if (rst || a == 0) begin
            d = '0;
            p = 1'b0;
        end
    endfunction

    // Compare process: every negedge, all outputs against the model.
    always @(negedge clk) begin : cmp
        logic [31:0] ed;
        logic        ep;
        expRead(ra_addr, ed, ep);
        checkOutput("ra_data", ra_data, ed);
        checkOutput("ra_pend", {31'b0, ra_pend}, {31'b0, ep});
        expRead(rb_addr, ed, ep);
        checkOutput("rb_data", rb_data, ed);
        checkOutput("rb_pend", {31'b0, rb_pend}, {31'b0, ep});
        checkOutput("test_data", test_data, rst ? 32'h0 : m_regs[test_addr]);
        checkOutput("clr_busy", {31'b0, clr_busy}, {31'b0, (!rst && clear_left > 0)});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        wa_en = 0; wb_en = 0; sb_set_en = 0; clr_req = 0;
        wa_addr = 0; wb_addr = 0; sb_set_addr = 0;
        wa_data = 0; wb_data = 0;
    endtask

    function automatic logic [ADDR_W-1:0] randAddr();
        return ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom_range(0, NREGS - 1));
    endfunction

    task automatic applyStimulus();
        wa_en       = ($urandom_range(0, 1) == 0);
        wa_addr     = randAddr();
        wa_data     = $urandom;
        wb_en       = ($urandom_range(0, 9) < 3);
        wb_addr     = randAddr();
        wb_data     = $urandom;
        sb_set_en   = ($urandom_range(0, 9) < 3);
        sb_set_addr = randAddr();
        clr_req     = ($urandom_range(0, 199) == 0);
        ra_addr     = randAddr();
        rb_addr     = randAddr();
        test_addr   = randAddr();
    endtask

    task automatic resetSweep();
        rst = 1;
        #1;
        checkOutput("rst_busy", {31'b0, clr_busy}, 32'h0);
        checkOutput("rst_ra_pend", {31'b0, ra_pend}, 32'h0);
        checkOutput("rst_rb_pend", {31'b0, rb_pend}, 32'h0);
        for (int i = 0; i < NREGS; i++) begin
            test_addr = ADDR_W'(i);
            #1;
            checkOutput("rst_test_data", test_data, 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        int busy_cycles;
        idleInputs();
        ra_addr = 0; rb_addr = 0; test_addr = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;

        wa_en = 1; wa_addr = 5; wa_data = 32'h1234_5678;
        cyc();
        idleInputs();
        ra_addr = 5;
        #1 checkOutput("wa_addr5", ra_data, 32'h1234_5678);

        wa_en = 1; wa_addr = 0; wa_data = 32'hFFFF_FFFF;
        cyc();
        idleInputs();
        ra_addr = 0; test_addr = 0;
        #1 checkOutput("zero_reg_ra", ra_data, 32'h0);
        checkOutput("zero_reg_test", test_data, 32'h0);

        wa_en = 1; wa_addr = 7; wa_data = 32'hAAAA_AAAA;
        wb_en = 1; wb_addr = 7; wb_data = 32'hBBBB_BBBB;
        cyc();
        idleInputs();
        rb_addr = 7;
        #1 checkOutput("wb_priority", rb_data, 32'hBBBB_BBBB);

        sb_set_en = 1; sb_set_addr = 9; rb_addr = 9;
        cyc();
        idleInputs();
        #1 checkOutput("sb_set9", {31'b0, rb_pend}, 32'h1);
        wa_en = 1; wa_addr = 9; wa_data = 32'h0000_0011;
        cyc();
        idleInputs();
        #1 checkOutput("wr_clears_pend", {31'b0, rb_pend}, 32'h0);
        wb_en = 1; wb_addr = 9; wb_data = 32'h0000_0099;
        sb_set_en = 1; sb_set_addr = 9;
        cyc();
        idleInputs();
        #1 checkOutput("set_wins_data", rb_data, 32'h0000_0099);
        checkOutput("set_wins_pend", {31'b0, rb_pend}, 32'h1);

        ra_addr = 4; wa_en = 1; wa_addr = 4; wa_data = 32'hCAFE_0000;
        #1;
`ifdef REGFILE_BYPASS_EN
        checkOutput("bypass_before", ra_data, 32'hCAFE_0000);
`else
        checkOutput("nobypass_before", ra_data, 32'h0);
`endif
        cyc();
        idleInputs();
        #1 checkOutput("write4_after", ra_data, 32'hCAFE_0000);

        for (int i = 0; i < NREGS; i++) begin
            wa_en = 1; wa_addr = ADDR_W'(i); wa_data = 32'h100 + i;
            cyc();
        end
        idleInputs();
        clr_req = 1;
        cyc();
        clr_req = 0;
        busy_cycles = 0;
        while (clr_busy && busy_cycles < 100) begin
            if (busy_cycles == 1) begin
                wa_en = 1; wa_addr = 3; wa_data = 32'hDEAD_BEEF;
            end else begin
                wa_en = 0;
            end
            cyc();
            busy_cycles++;
            if (busy_cycles == 2) begin
                test_addr = 3;
                #1 checkOutput("clr_drops_wr3", test_data, 32'h103);
            end
        end
        idleInputs();
        checkOutput("clr_busy_cycles", busy_cycles, 32'd32);
        for (int i = 0; i < NREGS; i++) begin
            test_addr = ADDR_W'(i);
            ra_addr = ADDR_W'(i);
            #1 checkOutput("clr_all_zero", test_data, 32'h0);
            checkOutput("clr_pend_zero", {31'b0, ra_pend}, 32'h0);
        end

        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            if (c == 1500) begin
                idleInputs();
                clr_req = 1;
                cyc();
                clr_req = 0;
                repeat (5) cyc();
                resetSweep();
                #1 checkOutput("busy_after_abort", {31'b0, clr_busy}, 32'h0);
            end
            cyc();
        end
        idleInputs();
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
